// File: rtl/data_mem_pipe.sv
// data_mem_pipe: pipelined LSU data memory with an in-order request FIFO and fixed access latency.
// Optional misaligned-access error responses are enabled by defining DATA_MEM_ERR_EN.
module data_mem_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int LAT       = 2,
  parameter int REQ_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_VALID,
  output logic                o_READY,
  input  logic [ADDR_W-1:0]   i_ADDR,
  input  logic                i_WREN,
  input  logic [DATA_W-1:0]   i_WDATA,
  input  logic [DATA_W/8-1:0] i_BMASK,
  output logic                o_RVALID,
  input  logic                i_RREADY,
  output logic [DATA_W-1:0]   o_RDATA,
  output logic                o_RERR
);
  localparam int BM_W  = DATA_W / 8;
  localparam int OFS_W = $clog2(BM_W);
  localparam int IDX_W = ADDR_W - OFS_W;
  localparam int WORDS = 2 ** IDX_W;
  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int ENT_W = ADDR_W + 1 + DATA_W + BM_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ENT_W-1:0]  fifo_mem [REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              ready_en_reg;
  logic              push, pop, empty, access, misaligned;
  logic [ADDR_W-1:0] work_addr_reg;
  logic              work_wren_reg;
  logic [DATA_W-1:0] work_wdata_reg;
  logic [BM_W-1:0]   work_bmask_reg;
  logic [IDX_W-1:0]  work_idx;
  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] rdata_reg;

  // Ready comes only from registered state, so a pop never frees a slot in the same cycle.
  assign empty    = (count_reg == '0);
  assign o_READY  = ready_en_reg & (count_reg != (PTR_W+1)'(REQ_DEPTH));
  assign push     = i_VALID & o_READY;
  assign work_idx = work_addr_reg[ADDR_W-1:OFS_W];
  assign o_RVALID = (state_reg == RESP);
  assign o_RDATA  = rdata_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    access     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          cnt_next   = CNT_W'(LAT - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (i_RREADY) begin
          if (!empty) begin
            pop        = 1'b1;
            cnt_next   = CNT_W'(LAT - 1);
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (access) rdata_reg <= (work_wren_reg || misaligned) ? '0 : mem[work_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {i_ADDR, i_WREN, i_WDATA, i_BMASK};
    if (pop)  {work_addr_reg, work_wren_reg, work_wdata_reg, work_bmask_reg} <= fifo_mem[rd_ptr_reg];
  end

  // Gated by reset so a write caught mid-flight by reset is never committed.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && access && work_wren_reg && !misaligned) begin
      for (int b = 0; b < BM_W; b++) begin
        if (work_bmask_reg[b]) mem[work_idx][b*8 +: 8] <= work_wdata_reg[b*8 +: 8];
      end
    end
  end

`ifdef DATA_MEM_ERR_EN
  logic rerr_reg;
  assign misaligned = (work_addr_reg[OFS_W-1:0] != '0);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    rerr_reg <= 1'b0;
    else if (access) rerr_reg <= misaligned;
  end
  assign o_RERR = rerr_reg;
`else
  logic unused_ofs;
  assign misaligned = 1'b0;
  assign unused_ofs = ^work_addr_reg[OFS_W-1:0];
  assign o_RERR     = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: directed and randomized checks of data_mem_pipe against a word-array reference model.
module tb_data_mem_pipe;
  localparam int LAT   = 2;
  localparam int N_RND = 60;

  typedef struct packed {
    logic [11:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } req_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid = 1'b0, wren = 1'b0, rready = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  bmask = '0;
  logic        ready, rvalid, rerr;
  logic [31:0] rdata;

  req_t        pend_q[$];
  logic [31:0] ref_mem [16];
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  data_mem_pipe #(.DATA_W(32), .ADDR_W(12), .LAT(LAT), .REQ_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_VALID(valid), .o_READY(ready),
    .i_ADDR(addr), .i_WREN(wren), .i_WDATA(wdata), .i_BMASK(bmask),
    .o_RVALID(rvalid), .i_RREADY(rready), .o_RDATA(rdata), .o_RERR(rerr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic [11:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    req_t r;
    r.addr = a; r.wren = w; r.wdata = d; r.bmask = m;
    return r;
  endfunction

  // Reference behaviour: one word array, each request applied in response order.
  function automatic void model_apply(input req_t r, output logic [31:0] d, output logic e);
    int  w;
    logic mis;
    w   = int'(r.addr[5:2]);
    mis = 1'b0;
`ifdef DATA_MEM_ERR_EN
    mis = (r.addr[1:0] != 2'b00);
`endif
    d = '0;
    e = mis;
    if (!mis) begin
      if (r.wren) begin
        for (int b = 0; b < 4; b++) begin
          if (r.bmask[b]) ref_mem[w][8*b +: 8] = r.wdata[8*b +: 8];
        end
      end else begin
        d = ref_mem[w];
      end
    end
  endfunction

  task automatic take_exp(output logic [31:0] d, output logic e);
    req_t r;
    d = '0;
    e = 1'b0;
    check("resp_pending", 64'(pend_q.size() != 0), 64'(1));
    if (pend_q.size() != 0) begin
      r = pend_q.pop_front();
      model_apply(r, d, e);
    end
  endtask

  // Called at a negedge; returns at a negedge with valid dropped.
  task automatic send(input req_t r);
    int t;
    t = 0;
    valid = 1'b1; addr = r.addr; wren = r.wren; wdata = r.wdata; bmask = r.bmask;
    while (!ready && t < 500) begin @(negedge clk); t++; end
    check("req_ready", 64'(ready), 64'(1));
    if (ready) begin
      @(posedge clk);
      pend_q.push_back(r);
      $display("[%0t] req  addr=%03h wren=%b wdata=%08h bmask=%b", $time, r.addr, r.wren, r.wdata, r.bmask);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic recv(input int stall, output int lat, output logic [31:0] got, output logic gerr);
    logic [31:0] ed;
    logic        ee;
    int          k;
    k = 0;
    rready = (stall == 0);
    while (!rvalid && k < 200) begin @(negedge clk); k++; end
    lat  = k;
    got  = rdata;
    gerr = rerr;
    check("rvalid_seen", 64'(rvalid), 64'(1));
    take_exp(ed, ee);
    for (int s = 0; s < stall; s++) begin
      check("stall_rdata", 64'(rdata), 64'(ed));
      check("stall_rerr", 64'(rerr), 64'(ee));
      @(negedge clk);
      check("stall_rvalid", 64'(rvalid), 64'(1));
    end
    rready = 1'b1;
    check("rdata", 64'(rdata), 64'(ed));
    check("rerr", 64'(rerr), 64'(ee));
    $display("[%0t] resp rdata=%08h rerr=%b lat=%0d", $time, rdata, rerr, lat);
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    int          lat, acc, k;
    logic [31:0] got, ed;
    logic        gerr, ee, took;
    req_t        bp [8];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_rerr", 64'(rerr), 64'(0));
    rst_n = 1'b1;
    check("post_rst_ready0", 64'(ready), 64'(0));
    @(negedge clk);
    check("post_rst_ready1", 64'(ready), 64'(1));

    // Known contents for the 16-word working region
    for (int w = 0; w < 16; w++) begin
      send(mk(12'(w * 4), 1'b1, $urandom, 4'hF));
      recv(0, lat, got, gerr);
    end

    // Basic write then read with latency
    send(mk(12'h010, 1'b1, 32'hDEADBEEF, 4'hF));
    recv(0, lat, got, gerr);
    check("lat_write", 64'(lat), 64'(LAT + 1));
    send(mk(12'h010, 1'b0, 32'h0, 4'h0));
    recv(0, lat, got, gerr);
    check("lat_read", 64'(lat), 64'(LAT + 1));
    check("basic_read", 64'(got), 64'(32'hDEADBEEF));

    // Byte masking
    send(mk(12'h020, 1'b1, 32'h11223344, 4'hF));
    recv(0, lat, got, gerr);
    send(mk(12'h020, 1'b1, 32'hAABBCCDD, 4'b0101));
    recv(0, lat, got, gerr);
    send(mk(12'h020, 1'b0, 32'h0, 4'h0));
    recv(0, lat, got, gerr);
    check("mask_read", 64'(got), 64'(32'h11BB33DD));

    // Misaligned write
    send(mk(12'h022, 1'b1, 32'hCAFEF00D, 4'hF));
    recv(0, lat, got, gerr);
`ifdef DATA_MEM_ERR_EN
    check("mis_rerr", 64'(gerr), 64'(1));
`else
    check("mis_rerr", 64'(gerr), 64'(0));
`endif
    send(mk(12'h020, 1'b0, 32'h0, 4'h0));
    recv(0, lat, got, gerr);
`ifdef DATA_MEM_ERR_EN
    check("mis_read", 64'(got), 64'(32'h11BB33DD));
`else
    check("mis_read", 64'(got), 64'(32'hCAFEF00D));
`endif

    // Backpressure: eight back-to-back reads with no response ready
    for (int i = 0; i < 8; i++) bp[i] = mk(12'((i + 3) * 4), 1'b0, 32'h0, 4'h0);
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 8) begin
        valid = 1'b1; addr = bp[acc].addr; wren = 1'b0; wdata = '0; bmask = '0;
      end else begin
        valid = 1'b0;
      end
      took = (acc < 8) && ready;
      @(posedge clk);
      if (took) begin
        pend_q.push_back(bp[acc]);
        $display("[%0t] req  addr=%03h wren=0 (backpressure)", $time, bp[acc].addr);
        acc++;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'(5));
    check("bp_ready_low", 64'(ready), 64'(0));
    recv(3, lat, got, gerr);
    for (int i = 0; i < 4; i++) recv(0, lat, got, gerr);

    // Reset while a write sits in its wait cycles
    send(mk(12'h030, 1'b1, ~ref_mem[12], 4'hF));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", 64'(rvalid), 64'(0));
    check("midrst_ready", 64'(ready), 64'(0));
    check("midrst_rdata", 64'(rdata), 64'(0));
    rst_n = 1'b1;
    pend_q.delete();
    @(negedge clk);
    check("midrst_ready1", 64'(ready), 64'(1));
    check("midrst_rvalid1", 64'(rvalid), 64'(0));
    send(mk(12'h030, 1'b0, 32'h0, 4'h0));
    recv(0, lat, got, gerr);

    // FIFO full while the head is popped: no same-cycle ready, then refill to full
    for (int i = 0; i < 5; i++) send(mk(12'(i * 4), 1'b0, 32'h0, 4'h0));
    valid = 1'b1; addr = 12'h01C; wren = 1'b1; wdata = 32'h5A5AA5A5; bmask = 4'hF;
    k = 0;
    while (!rvalid && k < 50) begin @(negedge clk); k++; end
    check("full_rvalid", 64'(rvalid), 64'(1));
    check("full_ready", 64'(ready), 64'(0));
    rready = 1'b1;
    take_exp(ed, ee);
    check("full_head_rdata", 64'(rdata), 64'(ed));
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    check("ready_after_pop", 64'(ready), 64'(1));
    if (ready) begin
      @(posedge clk);
      pend_q.push_back(mk(12'h01C, 1'b1, 32'h5A5AA5A5, 4'hF));
      $display("[%0t] req  addr=01c wren=1 wdata=5a5aa5a5 (refill)", $time);
    end
    @(negedge clk);
    valid = 1'b0;
    check("refull_ready", 64'(ready), 64'(0));
    for (int i = 0; i < 5; i++) recv(0, lat, got, gerr);
    check("queue_drained", 64'(pend_q.size()), 64'(0));

    // Randomized traffic with random response backpressure
    fork
      begin
        req_t r;
        for (int n = 0; n < N_RND; n++) begin
          r = mk(12'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
          send(r);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        int          got_n, cyc;
        logic        have;
        logic [31:0] rd_exp;
        logic        re_exp;
        got_n = 0; cyc = 0; have = 1'b0; rd_exp = '0; re_exp = 1'b0;
        while (got_n < N_RND && cyc < 5000) begin
          @(negedge clk);
          cyc++;
          if (rvalid) begin
            if (!have) begin take_exp(rd_exp, re_exp); have = 1'b1; end
            check("rnd_rdata", 64'(rdata), 64'(rd_exp));
            check("rnd_rerr", 64'(rerr), 64'(re_exp));
          end
          rready = ($urandom_range(0, 3) != 0);
          if (rvalid && rready) begin
            $display("[%0t] resp rdata=%08h rerr=%b (random)", $time, rdata, rerr);
            got_n++;
            have = 1'b0;
          end
        end
        rready = 1'b0;
        check("rnd_all_responses", 64'(got_n), 64'(N_RND));
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
